// File: rtl/ctrl_flow_pkg.sv
// Shared definitions for the control-flow initiator and its responder.
package ctrl_flow_pkg;

  // Commands understood by the responder.
  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_READ = 3'b001;
  localparam logic [2:0] CMD_PROC = 3'b010;

  // Initiator transaction states.
  typedef enum logic [2:0] {
    I_IDLE,
    I_ARM,
    I_ISSUE,
    I_DATA,
    I_WAIT,
    I_SEEN,
    I_FIN
  } init_state_e;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 8'hFF instead of wrapping.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_q, count_d;

  // Next count: step on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 8'hFF)) count_d = count_q + 8'd1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 8'h00;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ctrl_flow_initiator.sv
// Initiator: issues one READ or PROCESS command to the responder, waits for
// its IDLE->busy->WRITE handshake (or ERROR / timeout) and reports the outcome.
module ctrl_flow_initiator
  import ctrl_flow_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] seed,
  output logic [2:0]  cmd,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic [15:0] rsp_data,
  input  logic        rsp_ready,
  input  logic        rsp_error,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        fail,
  output logic        timed_out,
  output logic [7:0]  txn_count,
  output logic [7:0]  err_count
);

  init_state_e state_q, state_d;
  logic        mode_q, mode_d;
  logic [15:0] seed_q, seed_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [15:0] result_q, result_d;
  logic        fail_q, fail_d;
  logic        tout_q, tout_d;
  logic [7:0]  wcnt_inc;
  logic        tmo_hit;

  // The counter is compared after its increment so the FIN transition lands
  // exactly TIMEOUT_CYCLES cycles after entering I_WAIT; >= keeps the check
  // armed in I_SEEN if the WAIT->SEEN move won the tie.
  assign wcnt_inc = wcnt_q + 8'd1;
  assign tmo_hit  = (wcnt_inc >= TIMEOUT_CYCLES);

  // Next-state, datapath updates and command-bus drive.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    seed_d   = seed_q;
    wcnt_d   = wcnt_q;
    result_d = result_q;
    fail_d   = fail_q;
    tout_d   = tout_q;
    cmd      = CMD_NOP;
    tx_valid = 1'b0;
    tx_data  = 16'h0000;
    unique case (state_q)
      I_IDLE: begin
        if (start) begin
          mode_d  = mode;
          seed_d  = seed;
          fail_d  = 1'b0;
          tout_d  = 1'b0;
          state_d = I_ARM;
        end
      end
      I_ARM: begin
        if (rsp_ready) state_d = I_ISSUE;
      end
      I_ISSUE: begin
        wcnt_d = 8'h00;
        if (mode_q) begin
          cmd     = CMD_PROC;
          state_d = I_WAIT;
        end else begin
          cmd      = CMD_READ;
          tx_valid = 1'b1;
          tx_data  = seed_q;
          state_d  = I_DATA;
        end
      end
      I_DATA: begin
        tx_valid = 1'b1;
        tx_data  = seed_q;
        wcnt_d   = 8'h00;
        state_d  = I_WAIT;
      end
      I_WAIT: begin
        wcnt_d = wcnt_inc;
        if (rsp_error) begin
          fail_d  = 1'b1;
          state_d = I_FIN;
        end else if (!rsp_ready) begin
          state_d = I_SEEN;
        end else if (tmo_hit) begin
          fail_d  = 1'b1;
          tout_d  = 1'b1;
          state_d = I_FIN;
        end
      end
      I_SEEN: begin
        wcnt_d = wcnt_inc;
        if (rsp_error) begin
          fail_d  = 1'b1;
          state_d = I_FIN;
        end else if (rsp_ready) begin
          result_d = rsp_data;
          fail_d   = 1'b0;
          state_d  = I_FIN;
        end else if (tmo_hit) begin
          fail_d  = 1'b1;
          tout_d  = 1'b1;
          state_d = I_FIN;
        end
      end
      I_FIN: begin
        state_d = I_IDLE;
      end
      default: state_d = I_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= I_IDLE;
      mode_q   <= 1'b0;
      seed_q   <= 16'h0000;
      wcnt_q   <= 8'h00;
      result_q <= 16'h0000;
      fail_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      seed_q   <= seed_d;
      wcnt_q   <= wcnt_d;
      result_q <= result_d;
      fail_q   <= fail_d;
      tout_q   <= tout_d;
    end
  end

  // fail/timed_out are set on the way into I_FIN, so they are valid with
  // done and hold until the next accepted start.
  assign busy      = (state_q != I_IDLE);
  assign done      = (state_q == I_FIN);
  assign result    = result_q;
  assign fail      = fail_q;
  assign timed_out = tout_q;

  sat_counter8 u_txn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done),
    .count (txn_count)
  );

  sat_counter8 u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done && fail_q),
    .count (err_count)
  );

endmodule

// File: tb/tb_ctrl_flow_initiator.sv
// Bench: initiator against a behavioural responder with per-transaction
// latency / hang / error knobs; outcomes predicted at transaction level.
module tb_ctrl_flow_initiator;
  import ctrl_flow_pkg::*;

  localparam int          TMO      = 64;
  localparam logic [15:0] PROC_RES = 16'h5A5A;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic [2:0]  cmd;
  logic [15:0] tx_data, rsp_data, result;
  logic        tx_valid, rsp_ready, rsp_error, busy, done, fail, timed_out;
  logic [7:0]  txn_count, err_count;

  always #5 clk = ~clk;

  ctrl_flow_initiator #(.TIMEOUT_CYCLES(8'd64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
    .cmd(cmd), .tx_data(tx_data), .tx_valid(tx_valid),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .rsp_error(rsp_error),
    .busy(busy), .done(done), .result(result), .fail(fail),
    .timed_out(timed_out), .txn_count(txn_count), .err_count(err_count)
  );

  // ---------------- responder model ----------------
  typedef enum logic [2:0] {R_IDLE, R_GOT, R_BUSY, R_WRITE, R_ERR, R_BOTH} rsp_st_e;
  rsp_st_e     rs;
  int          rcnt;
  logic [15:0] rout;
  int          k_lat  = 1;
  bit          k_hang = 0, k_lerr = 0, k_both = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs <= R_IDLE; rcnt <= 0; rout <= 16'h0000;
    end else begin
      case (rs)
        R_IDLE:
          if (cmd == CMD_READ && tx_valid) rs <= R_GOT;
          else if (cmd == CMD_PROC) begin rs <= R_BUSY; rcnt <= 0; rout <= PROC_RES; end
        R_GOT:
          if (!tx_valid) rs <= R_IDLE;
          else if (tx_data[15]) begin rs <= R_ERR; rcnt <= 0; end
          else begin rs <= R_BUSY; rcnt <= 0; rout <= {tx_data[14:0], 1'b0}; end
        R_BUSY: begin
          rcnt <= rcnt + 1;
          if (!k_hang && rcnt >= k_lat - 1) begin
            rs   <= k_lerr ? R_ERR : (k_both ? R_BOTH : R_WRITE);
            rcnt <= 0;
          end
        end
        R_ERR: begin
          rcnt <= rcnt + 1;
          if (rcnt >= 2) rs <= R_IDLE;
        end
        default: rs <= R_IDLE;
      endcase
    end
  end

  assign rsp_ready = (rs == R_IDLE) || (rs == R_WRITE) || (rs == R_BOTH);
  assign rsp_error = (rs == R_ERR) || (rs == R_BOTH);
  assign rsp_data  = (rs == R_WRITE || rs == R_BOTH) ? rout : 16'h0000;

  // ---------------- bookkeeping ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          nvec = 0, nbad = 0;
  logic [15:0] res_m = 16'h0000;
  int          txn_m = 0, err_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, ".cmd"},      32'(cmd),       32'd0);
    chk({tag, ".tx_data"},  32'(tx_data),   32'd0);
    chk({tag, ".tx_valid"}, 32'(tx_valid),  32'd0);
    chk({tag, ".busy"},     32'(busy),      32'd0);
    chk({tag, ".done"},     32'(done),      32'd0);
    chk({tag, ".fail"},     32'(fail),      32'd0);
    chk({tag, ".timed_out"},32'(timed_out), 32'd0);
    chk({tag, ".result"},   32'(result),    32'd0);
    chk({tag, ".txn"},      32'(txn_count), 32'd0);
    chk({tag, ".err"},      32'(err_count), 32'd0);
  endtask

  // Transaction-level outcome: relative done cycle (start cycle = 0),
  // fail / timeout flags and the result that should be visible at done.
  function automatic void predict(input bit md, input logic [15:0] sd, input int lat,
                                  input bit hang, input bit lerr, input bit both,
                                  output int drel, output bit f, output bit to,
                                  output logic [15:0] res);
    int ent;
    ent = md ? 3 : 4;          // first cycle spent waiting for the responder
    f = 0; to = 0; res = res_m;
    if (!md && sd[15]) begin
      drel = 5; f = 1;         // responder rejects the data immediately
    end else if (hang || lat >= TMO) begin
      drel = ent + TMO; f = 1; to = 1;
    end else begin
      drel = ent + lat + 1;
      if (lerr || both) f = 1;
      else res = md ? PROC_RES : {sd[14:0], 1'b0};
    end
  endfunction

  // One transaction. xs: 0 = no extra start, -1 = random extra start while
  // busy (up to and including the done cycle), else that relative cycle.
  task automatic run_txn(input bit md, input logic [15:0] sd, input int lat,
                         input bit hang, input bit lerr, input bit both, input int xs);
    int drel, s, first, ndone, w, xp;
    bit ef, eto, vld;
    logic [15:0] eres;
    predict(md, sd, lat, hang, lerr, both, drel, ef, eto, eres);
    xp = (xs < 0) ? $urandom_range(drel, 2) : xs;
    k_lat = lat; k_hang = hang; k_lerr = lerr; k_both = both;
    w = 0;
    while ((rs != R_IDLE || busy) && w < 300) begin @(negedge clk); w++; end
    chk("idle_wait", 32'(w < 300), 32'd1);
    @(negedge clk);
    start = 1'b1; mode = md; seed = sd; s = cyc; first = -1; ndone = 0;
    for (int r = 1; r <= drel + 3; r++) begin
      @(negedge clk);
      start = (r == xp);
      mode  = 1'($urandom);
      seed  = 16'($urandom);     // must not disturb the latched copy
      vld   = !md && (r == 2 || r == 3);
      chk("cmd", 32'(cmd), (r == 2) ? (md ? 32'(CMD_PROC) : 32'(CMD_READ)) : 32'd0);
      chk("tx_valid", 32'(tx_valid), 32'(vld));
      chk("tx_data", 32'(tx_data), vld ? 32'(sd) : 32'd0);
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = cyc - s;
          chk("fail", 32'(fail), 32'(ef));
          chk("timed_out", 32'(timed_out), 32'(eto));
          chk("result", 32'(result), 32'(eres));
          k_hang = 0;
        end
      end
      if (r == drel + 1) begin
        res_m = eres;
        if (txn_m < 255) txn_m++;
        if (ef && err_m < 255) err_m++;
        chk("busy_after", 32'(busy), 32'd0);
        chk("txn_count", 32'(txn_count), 32'(txn_m));
        chk("err_count", 32'(err_count), 32'(err_m));
      end
    end
    start = 1'b0;
    k_hang = 0;
    chk("done_rel", 32'(first), 32'(drel));
    chk("done_cnt", 32'(ndone), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; k_hang = 0;
    #1 rst_chk("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    res_m = 16'h0000; txn_m = 0; err_m = 0;
  endtask

  initial begin
    int w;
    do_reset();

    // Basic READ: result is twice the seed, 21 cycles start->done at L=16.
    run_txn(0, 16'h0010, 16, 0, 0, 0, 0);
    // Responder rejects the data word.
    run_txn(0, 16'h8000, 16, 0, 0, 0, 0);
    // Responder never comes back: timeout, READ and PROCESS.
    run_txn(0, 16'h0033, 16, 1, 0, 0, 0);
    run_txn(1, 16'h0000, 16, 1, 0, 0, 0);
    // Response on the timeout cycle wins; one cycle later it loses.
    run_txn(0, 16'h0101, 63, 0, 0, 0, 0);
    run_txn(0, 16'h0202, 64, 0, 0, 0, 0);
    // PROCESS success, late error, error+ready together.
    run_txn(1, 16'h0000, 5, 0, 0, 0, 0);
    run_txn(0, 16'h1234, 7, 0, 1, 0, 0);
    run_txn(1, 16'h0000, 9, 0, 0, 1, 0);
    // Starts while busy and in the done cycle are dropped.
    run_txn(0, 16'h0444, 6, 0, 0, 0, 5);
    run_txn(0, 16'h0555, 6, 0, 0, 0, 11);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      bit md;
      logic [15:0] sd;
      md = 1'($urandom);
      sd = 16'($urandom);
      sd[15] = ($urandom_range(3, 0) == 0);
      run_txn(md, sd, $urandom_range(24, 1), $urandom_range(9, 0) == 0,
              $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0,
              ($urandom_range(1, 0) == 1) ? -1 : 0);
    end

    // Reset while the initiator is in I_WAIT.
    k_hang = 1; k_lat = 1; k_lerr = 0; k_both = 0;
    w = 0;
    while ((rs != R_IDLE || busy) && w < 300) begin @(negedge clk); w++; end
    @(negedge clk);
    start = 1'b1; mode = 1'b0; seed = 16'h0100;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_pre_rst", 32'(busy), 32'd1);
    #2 do_reset();
    run_txn(1, 16'h0000, 4, 0, 0, 0, 0);

    // Counter saturation over 256 failing transactions.
    @(negedge clk);
    #2 do_reset();
    for (int i = 0; i < 256; i++) run_txn(0, 16'h8000, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("txn_sat", 32'(txn_count), 32'hFF);
    chk("err_sat", 32'(err_count), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/ctrl_flow_initiator.md
CTRL_FLOW_INITIATOR -- requirements
Module: ctrl_flow_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 8'd64: maximum cycles in WAIT before a timeout is declared.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 start  input  1  pulse that requests one transaction; ignored unless busy=0.
REQ-005 mode  input  1  0 = READ transaction (cmd 3'b001 with data), 1 = PROCESS-only transaction (cmd 3'b010, no data).
REQ-006 seed  input  16  data word sent to the responder in READ mode; sampled when start is accepted.
REQ-007 cmd  output  3  command to the responder.
REQ-008 tx_data  output  16  data word to the responder.
REQ-009 tx_valid  output  1  qualifies tx_data and cmd 3'b001.
REQ-010 rsp_data  input  16  responder result; nonzero only in the responder's WRITE state.
REQ-011 rsp_ready  input  1  high when the responder is in IDLE or WRITE.
REQ-012 rsp_error  input  1  high when the responder is in ERROR.
REQ-013 busy  output  1  transaction in progress.
REQ-014 done  output  1  one-cycle pulse at transaction end, whether success or failure.
REQ-015 result  output  16  last captured rsp_data; held until the next success.
REQ-016 fail  output  1  registered with done; 1 if the transaction ended by rsp_error or timeout.
REQ-017 timed_out  output  1  registered with done; 1 if the transaction ended by timeout.
REQ-018 txn_count, err_count  output  8 each  count of completed transactions and of failed ones; both saturate at 8'hFF.

Function
REQ-019 States: I_IDLE, I_ARM, I_ISSUE, I_DATA, I_WAIT, I_SEEN, I_FIN.
- I_IDLE: start=1 latches mode and seed, sets busy, and moves to I_ARM.
REQ-020 I_ARM: stays until rsp_ready=1, then moves to I_ISSUE.
REQ-021 I_ISSUE lasts exactly one cycle and drives the command:
- mode 0: cmd=3'b001, tx_valid=1, tx_data=seed, next I_DATA.
- mode 1: cmd=3'b010, tx_valid=0, next I_WAIT.
REQ-022 I_DATA lasts exactly one cycle: cmd=3'b000, tx_valid=1, tx_data=seed, next I_WAIT.
REQ-023 Default drive in every other state: cmd=3'b000, tx_valid=0, tx_data=16'h0000.
REQ-024 I_WAIT: when rsp_ready=0 is first seen, move to I_SEEN. This is the responder leaving IDLE.
REQ-025 I_SEEN: rsp_ready=1 means the responder is in WRITE.
- Capture result=rsp_data and fail=0, then move to I_FIN.
REQ-026 rsp_error=1 in I_WAIT or I_SEEN sets fail=1 and moves to I_FIN; result is unchanged.
REQ-027 rsp_error has priority over rsp_ready when both are high in the same cycle.
REQ-028 Timeout:
- An 8-bit wait counter clears on entry to I_WAIT and increments each cycle in I_WAIT and I_SEEN.
- When the counter reaches TIMEOUT_CYCLES, set fail=1 and timed_out=1, and move to I_FIN.
- A response event in that same cycle takes priority over the timeout.
REQ-029 I_FIN lasts one cycle:
- Assert done and increment txn_count.
- Increment err_count if fail=1.
- Deassert busy next cycle and return to I_IDLE.
REQ-030 start while busy=1 is dropped and not queued.
- A start that arrives in the I_FIN cycle is also dropped.
REQ-031 Latency, READ mode, with a responder whose internal counter starts at 0: done asserts 21 cycles after the start cycle.

Reset
REQ-032 rst_n=0 forces the following immediately, at any point in a transaction:
- State I_IDLE.
- cmd=0, tx_data=0, tx_valid=0.
- busy=0, done=0, fail=0, timed_out=0.
- result=0, txn_count=0, err_count=0, wait counter=0.
REQ-033 The first transaction after reset release starts from I_IDLE and never replays a command that was interrupted.

Structure
REQ-034 A shared package ctrl_flow_pkg holds:
- the responder command constants CMD_NOP=3'b000, CMD_READ=3'b001, CMD_PROC=3'b010;
- the initiator state typedef.
REQ-035 One sub-module, sat_counter8, SHALL be instantiated twice, for txn_count and err_count.
- Ports: clk, rst_n, inc, count[7:0]; the count saturates at 8'hFF.

Verification
REQ-036 Reset release, then start with mode=0 and seed=16'h0010 against the paired responder.
- Expect done once, result=16'h0020, fail=0, txn_count=1.
REQ-037 Start with mode=0 and seed=16'h8000.
- Expect the responder to enter ERROR, then done with fail=1, timed_out=0, err_count=1, and result unchanged.
REQ-038 Responder model holds rsp_ready=0 permanently after the command.
- Expect done exactly 64 cycles after entering I_WAIT, with fail=1 and timed_out=1.
REQ-039 Pulse start again during busy.
- Expect no second transaction and txn_count to advance by only 1.
REQ-040 Assert rst_n=0 during I_WAIT.
- Expect all outputs zero in the same cycle.
- After release, a fresh mode=1 transaction completes with fail=0.
REQ-041 Run 256 failing transactions.
- Expect err_count=8'hFF and txn_count=8'hFF, with no wrap.
